// File: rtl/gbc_video_pkg.sv
// gbc_video_pkg
// Shared definitions for the GBC video subsystem: OAM window, DMA
// register address and the OAM DMA engine state encoding.
// No ports (package).
package gbc_video_pkg;

    localparam logic [15:0] OAM_BASE = 16'hFE00;
    localparam int unsigned OAM_SIZE = 32'd160;
    localparam logic [15:0] REG_DMA  = 16'hFF46;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DELAY = 3'd1,
        READ  = 3'd2,
        WAIT  = 3'd3,
        WRITE = 3'd4
    } oam_dma_state_t;

endpackage

// File: rtl/gbc_oam_dma_srcmap.sv
// gbc_oam_dma_srcmap
// Combinational source address former for the OAM DMA engine.
// Build option: OAM_DMA_ECHO_MAP_EN folds echo pages E0-FF onto C0-DF
// so a DMA from echo RAM reads WRAM directly; without it the page
// passes through and the system bus decoder resolves E0-FF.
// Ports:
//   Page    in  8   source page (high address byte)
//   Index   in  8   byte index within the page
//   Address out 16  source read address
module gbc_oam_dma_srcmap (
    input  logic [7:0]  Page,
    input  logic [7:0]  Index,
    output logic [15:0] Address
);

    logic [7:0] page_s;

    // Page fold (optional) and address concatenation.
    always_comb begin
        page_s = Page;
`ifdef OAM_DMA_ECHO_MAP_EN
        if (Page >= 8'hE0) begin
            page_s = Page - 8'h20;
        end else begin
            page_s = Page;
        end
`endif
        Address = {page_s, Index};
    end

endmodule

// File: rtl/gbc_oam_dma.sv
// gbc_oam_dma
// OAM DMA engine: a write to FF46 copies OAM_BYTES bytes from page XX00
// into OAM offsets 00.. one byte per ClkEn step. Active blocks the CPU
// bus for the whole transfer. Build option OAM_DMA_ECHO_MAP_EN (see
// gbc_oam_dma_srcmap) folds echo-RAM source pages onto WRAM.
// Ports:
//   Clk, nReset               clock, async active-low reset
//   ClkEn                     M-cycle enable
//   RegWrite, RegD, RegQ      FF46 write strobe / data / readback
//   SrcAddress, SrcAccess     source read request
//   SrcDataReady, SrcData     source read response
//   OamAddress, OamD, OamWrite OAM write port (OamWrite in a ClkEn cycle)
//   Active                    transfer in progress
module gbc_oam_dma
    import gbc_video_pkg::*;
#(
    parameter int unsigned OAM_BYTES   = OAM_SIZE,
    parameter int unsigned START_DELAY = 32'd1
) (
    input  logic        Clk,
    input  logic        nReset,
    input  logic        ClkEn,
    input  logic        RegWrite,
    input  logic [7:0]  RegD,
    output logic [7:0]  RegQ,
    output logic [15:0] SrcAddress,
    output logic        SrcAccess,
    input  logic        SrcDataReady,
    input  logic [7:0]  SrcData,
    output logic [7:0]  OamAddress,
    output logic [7:0]  OamD,
    output logic        OamWrite,
    output logic        Active
);

    localparam logic [7:0] LAST_INDEX = 8'(OAM_BYTES - 32'd1);
    localparam logic [7:0] DELAY_LOAD = 8'(START_DELAY);

    oam_dma_state_t state_r, state_s;
    logic [7:0]     reg_q_r, reg_q_s;
    logic [7:0]     index_r, index_s;
    logic [7:0]     delay_r, delay_s;
    logic [7:0]     data_r, data_s;
    logic [15:0]    src_addr_r, src_addr_s;
    logic           src_access_r, src_access_s;
    logic [15:0]    map_addr_s;
    logic           start_s;
    logic           oam_write_s;

    gbc_oam_dma_srcmap u_srcmap (
        .Page    (reg_q_r),
        .Index   (index_r),
        .Address (map_addr_s)
    );

    // State and datapath registers.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_r      <= IDLE;
            reg_q_r      <= 8'hFF;
            index_r      <= 8'h00;
            delay_r      <= 8'h00;
            data_r       <= 8'h00;
            src_addr_r   <= 16'h0000;
            src_access_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            reg_q_r      <= reg_q_s;
            index_r      <= index_s;
            delay_r      <= delay_s;
            data_r       <= data_s;
            src_addr_r   <= src_addr_s;
            src_access_r <= src_access_s;
        end
    end

    // Next-state logic. A FF46 write in any state (re)starts the engine;
    // WAIT advances on the source handshake regardless of ClkEn.
    always_comb begin
        state_s      = state_r;
        reg_q_s      = reg_q_r;
        index_s      = index_r;
        delay_s      = delay_r;
        data_s       = data_r;
        src_addr_s   = src_addr_r;
        src_access_s = src_access_r;
        start_s      = RegWrite & ClkEn;

        if (start_s) begin
            reg_q_s      = RegD;
            delay_s      = DELAY_LOAD;
            src_access_s = 1'b0;
            state_s      = DELAY;
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = IDLE;
                end
                DELAY: begin
                    if (ClkEn) begin
                        if (delay_r <= 8'd1) begin
                            index_s = 8'h00;
                            state_s = READ;
                        end else begin
                            delay_s = delay_r - 8'd1;
                        end
                    end else begin
                        state_s = DELAY;
                    end
                end
                READ: begin
                    if (ClkEn) begin
                        src_addr_s   = map_addr_s;
                        src_access_s = 1'b1;
                        state_s      = WAIT;
                    end else begin
                        state_s = READ;
                    end
                end
                WAIT: begin
                    if (SrcDataReady) begin
                        data_s       = SrcData;
                        src_access_s = 1'b0;
                        state_s      = WRITE;
                    end else begin
                        state_s = WAIT;
                    end
                end
                WRITE: begin
                    if (ClkEn) begin
                        if (index_r == LAST_INDEX) begin
                            state_s = IDLE;
                        end else begin
                            index_s = index_r + 8'd1;
                            state_s = READ;
                        end
                    end else begin
                        state_s = WRITE;
                    end
                end
                default: begin
                    src_access_s = 1'b0;
                    state_s      = IDLE;
                end
            endcase
        end
    end

    // OAM strobe: a restart drops the byte in flight unless it is the
    // last byte, which is allowed to land before the new transfer.
    always_comb begin
        oam_write_s = 1'b0;
        if ((state_r == WRITE) && ClkEn) begin
            oam_write_s = ~RegWrite | (index_r == LAST_INDEX);
        end else begin
            oam_write_s = 1'b0;
        end
    end

    assign RegQ       = reg_q_r;
    assign SrcAddress = src_addr_r;
    assign SrcAccess  = src_access_r;
    assign OamAddress = index_r;
    assign OamD       = data_r;
    assign OamWrite   = oam_write_s;
    assign Active     = (state_r != IDLE);

endmodule

// File: tb/tb_gbc_oam_dma.sv
// tb_gbc_oam_dma
// Directed bench for gbc_oam_dma: full copy with zero-wait and slow
// source, mid-transfer restart, echo page handling, async reset.
module tb_gbc_oam_dma;

    logic        Clk = 1'b0;
    logic        nReset = 1'b1;
    logic        ClkEn = 1'b0;
    logic        RegWrite = 1'b0;
    logic [7:0]  RegD = 8'h00;
    logic [7:0]  RegQ;
    logic [15:0] SrcAddress;
    logic        SrcAccess;
    logic        SrcDataReady = 1'b0;
    logic [7:0]  SrcData = 8'h00;
    logic [7:0]  OamAddress;
    logic [7:0]  OamD;
    logic        OamWrite;
    logic        Active;

    gbc_oam_dma dut (
        .Clk          (Clk),
        .nReset       (nReset),
        .ClkEn        (ClkEn),
        .RegWrite     (RegWrite),
        .RegD         (RegD),
        .RegQ         (RegQ),
        .SrcAddress   (SrcAddress),
        .SrcAccess    (SrcAccess),
        .SrcDataReady (SrcDataReady),
        .SrcData      (SrcData),
        .OamAddress   (OamAddress),
        .OamD         (OamD),
        .OamWrite     (OamWrite),
        .Active       (Active)
    );

    always #5 Clk = ~Clk;

    // ClkEn high one Clk in four, driven just after the rising edge.
    logic [1:0] phase = 2'd0;
    always @(posedge Clk) begin
        #1;
        phase = phase + 2'd1;
        ClkEn = (phase == 2'd0);
    end

    // Source memory model: data = low address byte ^ 5A, ready after src_wait cycles.
    int src_wait = 0;
    int acc_cycles = 0;
    always @(posedge Clk) begin
        #1;
        if (SrcAccess) begin
            SrcDataReady = (acc_cycles >= src_wait);
            SrcData      = SrcAddress[7:0] ^ 8'h5A;
            acc_cycles   = acc_cycles + 1;
        end else begin
            SrcDataReady = 1'b0;
            acc_cycles   = 0;
        end
    end

    // Bus observers sampled on the falling edge.
    logic [7:0]  oam_mem [0:255];
    logic [15:0] src_q [$];
    int wr_cnt = 0, exp_next = 0, order_err = 0, en_err = 0, stall_cnt = 0;
    logic prev_acc = 1'b0;
    always @(negedge Clk) begin
        if (OamWrite) begin
            if (OamAddress != exp_next[7:0]) order_err = order_err + 1;
            if (!ClkEn) en_err = en_err + 1;
            oam_mem[OamAddress] = OamD;
            wr_cnt   = wr_cnt + 1;
            exp_next = exp_next + 1;
        end
        if (SrcAccess && !prev_acc) src_q.push_back(SrcAddress);
        if (SrcAccess && !SrcDataReady) stall_cnt = stall_cnt + 1;
        prev_acc = SrcAccess;
    end

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_mon();
        for (int i = 0; i < 256; i++) oam_mem[i] = 8'h00;
        src_q.delete();
        wr_cnt = 0; exp_next = 0; order_err = 0; en_err = 0; stall_cnt = 0;
    endtask

    task automatic wait_en();
        do begin
            @(posedge Clk); #2;
        end while (!ClkEn);
    endtask

    task automatic do_write(input logic [7:0] d);
        wait_en();
        RegWrite = 1'b1;
        RegD     = d;
        @(posedge Clk); #2;
        RegWrite = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int cyc;
        cyc = 0;
        while (Active && cyc < 8000) begin
            @(posedge Clk); #2;
            cyc++;
        end
        check(tag, 32'(Active), 32'd0);
    endtask

    task automatic wait_src(input logic [15:0] addr, input string tag);
        int cyc;
        cyc = 0;
        while (!(SrcAccess && SrcAddress == addr) && cyc < 8000) begin
            @(posedge Clk); #2;
            cyc++;
        end
        check(tag, 32'(SrcAddress), 32'(addr));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_regq"},  32'(RegQ),       32'h0000_00FF);
        check({tag, "_saddr"}, 32'(SrcAddress), 32'h0000_0000);
        check({tag, "_sacc"},  32'(SrcAccess),  32'd0);
        check({tag, "_oaddr"}, 32'(OamAddress), 32'd0);
        check({tag, "_oamd"},  32'(OamD),       32'd0);
        check({tag, "_owr"},   32'(OamWrite),   32'd0);
        check({tag, "_act"},   32'(Active),     32'd0);
    endtask

    task automatic check_oam(input string tag);
        for (int i = 0; i < 160; i++) begin
            check(tag, 32'(oam_mem[i]), 32'(8'(i) ^ 8'h5A));
        end
    endtask

    logic [7:0] echo_page;
    int steps, cyc;
    logic en_now, done;

    initial begin
`ifdef OAM_DMA_ECHO_MAP_EN
        echo_page = 8'hC3;
`else
        echo_page = 8'hE3;
`endif
        // Power-on reset.
        #3 nReset = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (3) @(posedge Clk);
        #2 nReset = 1'b1;
        repeat (4) @(posedge Clk);

        // Zero-wait copy from page C1.
        clear_mon();
        src_wait = 0;
        do_write(8'hC1);
        check("t1_active_rise", 32'(Active), 32'd1);
        check("t1_regq", 32'(RegQ), 32'h0000_00C1);
        steps = 0; cyc = 0; done = 1'b0;
        while (!done && cyc < 8000) begin
            @(negedge Clk);
            en_now = ClkEn;
            @(posedge Clk); #2;
            cyc++;
            if (en_now) steps++;
            if (!Active) done = 1'b1;
        end
        check("t1_steps", 32'(steps), 32'd321);
        check("t1_wr_cnt", 32'(wr_cnt), 32'd160);
        check("t1_order", 32'(order_err), 32'd0);
        check("t1_wr_en", 32'(en_err), 32'd0);
        check("t1_stalls", 32'(stall_cnt), 32'd0);
        check("t1_src_first", 32'(src_q[0]), 32'h0000_C100);
        check("t1_src_last", 32'(src_q[159]), 32'h0000_C19F);
        check("t1_regq_end", 32'(RegQ), 32'h0000_00C1);
        check_oam("t1_oam");

        // Same copy with the source 3 Clk late on every read.
        clear_mon();
        src_wait = 3;
        do_write(8'hC1);
        wait_idle("t2_idle");
        check("t2_wr_cnt", 32'(wr_cnt), 32'd160);
        check("t2_order", 32'(order_err), 32'd0);
        check("t2_wr_en", 32'(en_err), 32'd0);
        check("t2_stalls", 32'(stall_cnt), 32'd480);
        check_oam("t2_oam");

        // Restart with page 90 while byte 40h is waiting to be written.
        clear_mon();
        src_wait = 0;
        do_write(8'h80);
        wait_src(16'h8040, "t3_reach_40");
        wait_en();
        RegWrite = 1'b1;
        RegD     = 8'h90;
        #1 check("t3_no_write", 32'(OamWrite), 32'd0);
        @(posedge Clk); #2;
        RegWrite = 1'b0;
        check("t3_wr_before", 32'(wr_cnt), 32'd64);
        exp_next = 0;
        check("t3_active", 32'(Active), 32'd1);
        check("t3_regq", 32'(RegQ), 32'h0000_0090);
        wait_en();
        @(posedge Clk); #2;
        check("t3_delay_noacc", 32'(SrcAccess), 32'd0);
        wait_en();
        @(posedge Clk); #2;
        check("t3_first_addr", 32'(SrcAddress), 32'h0000_9000);
        check("t3_first_acc", 32'(SrcAccess), 32'd1);
        wait_idle("t3_idle");
        check("t3_wr_cnt", 32'(wr_cnt), 32'd224);
        check("t3_order", 32'(order_err), 32'd0);
        check_oam("t3_oam");

        // Echo page E3.
        clear_mon();
        do_write(8'hE3);
        wait_idle("t4_idle");
        check("t4_regq", 32'(RegQ), 32'h0000_00E3);
        check("t4_src_cnt", 32'(src_q.size()), 32'd160);
        for (int i = 0; i < 160; i++) begin
            check("t4_src_addr", 32'(src_q[i]), 32'({echo_page, 8'(i)}));
        end

        // Async reset at index 20h.
        clear_mon();
        do_write(8'hC1);
        wait_src(16'hC120, "t5_reach_20");
        #1 nReset = 1'b0;
        #1 check_reset_outputs("t5_async");
        repeat (2) @(posedge Clk);
        #2 nReset = 1'b1;
        wr_cnt = 0;
        repeat (40) @(posedge Clk);
        #2;
        check("t5_idle_nowr", 32'(wr_cnt), 32'd0);
        check("t5_idle_act", 32'(Active), 32'd0);
        check("t5_idle_regq", 32'(RegQ), 32'h0000_00FF);
        check("t5_idle_sacc", 32'(SrcAccess), 32'd0);
        clear_mon();
        do_write(8'hC1);
        wait_idle("t5_resume_idle");
        check("t5_resume_cnt", 32'(wr_cnt), 32'd160);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
